// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: logic/arith ops finish in one cycle, shifts move one bit per cycle.
// Operands are captured at acceptance; result/zero/overflow only change on entry to DONE.
module ula_multiciclo #(
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                Op,
    input  logic [DATA_W-1:0]         A,
    input  logic [DATA_W-1:0]         B,
    input  logic [$clog2(DATA_W)-1:0] shamt,
    output logic [DATA_W-1:0]         result,
    output logic                      zero,
    output logic                      overflow,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                dbg_state_o
);
    // Handshake: start is accepted on a rising edge only while busy=0 (IDLE or DONE);
    // done is high for exactly one cycle and qualifies result/zero/overflow.
    localparam int SHW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        K_SLL = 2'd0,
        K_SRL = 2'd1,
        K_SRA = 2'd2
    } shift_kind_e;

    state_e             state_q, state_d;
    shift_kind_e        kind_q, kind_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [DATA_W-1:0]  alu_res;
    logic               alu_ovf;
    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;
    logic               is_shift;
    logic [SHW-1:0]     amt;
    shift_kind_e        kind_in;
    logic [DATA_W-1:0]  sh_step;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Op)
            4'b0110: begin
                alu_res = sum;
                alu_ovf = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
            end
            4'b0111: begin
                alu_res = diff;
                alu_ovf = (A[DATA_W-1] != B[DATA_W-1]) && (diff[DATA_W-1] != A[DATA_W-1]);
            end
            4'b1000: alu_res = A & B;
            4'b1001: alu_res = A | B;
            4'b1010: alu_res = A ^ B;
            4'b1011: alu_res = ~(A | B);
            // Signed compare on the operands themselves, immune to wrap of A-B.
            4'b1100: alu_res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1101: alu_res = {{(DATA_W-1){1'b0}}, (A < B)};
            4'b1110: alu_res = DATA_W'(B[15:0]) << 16;
            4'b1111: alu_res = A | DATA_W'(B[15:0]);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        is_shift = (Op <= 4'd5);
        amt      = (Op <= 4'd2) ? shamt : A[SHW-1:0];
        case (Op)
            4'd1, 4'd4: kind_in = K_SRL;
            4'd2, 4'd5: kind_in = K_SRA;
            default:    kind_in = K_SLL;
        endcase
    end

    always_comb begin
        case (kind_q)
            K_SRL:   sh_step = {1'b0, sh_q[DATA_W-1:1]};
            K_SRA:   sh_step = {sh_q[DATA_W-1], sh_q[DATA_W-1:1]};
            default: sh_step = {sh_q[DATA_W-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (!is_shift) begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        state_d  = S_DONE;
                    end else if (amt == '0) begin
                        result_d = B;
                        zero_d   = (B == '0);
                        ovf_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        sh_d    = B;
                        cnt_d   = amt;
                        kind_d  = kind_in;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                sh_d  = sh_step;
                cnt_d = cnt_q - 1'b1;
                // Last bit lands in the same edge that publishes the result.
                if (cnt_q == SHW'(1)) begin
                    result_d = sh_step;
                    zero_d   = (sh_step == '0);
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            kind_q   <= K_SLL;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q == S_SHIFT);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized bench for ula_multiciclo against an arithmetic reference model.
module tb_ula_multiciclo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_prev;

    ula_multiciclo #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Op(Op), .A(A), .B(B), .shamt(shamt),
        .result(result), .zero(zero), .overflow(overflow), .busy(busy), .done(done),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on wide signed integers.
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output logic [31:0] r, output logic ov,
                           output int n);
        longint la, lb, s;
        logic signed [31:0] bs;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        bs = b;
        r = 0; ov = 0; n = 0;
        case (op)
            4'h0: begin n = sh;      r = b << sh; end
            4'h1: begin n = sh;      r = b >> sh; end
            4'h2: begin n = sh;      r = bs >>> sh; end
            4'h3: begin n = a[4:0];  r = b << a[4:0]; end
            4'h4: begin n = a[4:0];  r = b >> a[4:0]; end
            4'h5: begin n = a[4:0];  r = bs >>> a[4:0]; end
            4'h6: begin s = la + lb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h7: begin s = la - lb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a | b);
            4'hC: r = (la < lb) ? 32'd1 : 32'd0;
            4'hD: r = (a < b) ? 32'd1 : 32'd0;
            4'hE: r = {b[15:0], 16'h0};
            default: r = a | {16'h0, b[15:0]};
        endcase
    endtask

    // Issues one op, scrambles inputs afterwards, pokes start while busy, checks timing and outputs.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        logic [31:0] r, got_exp;
        logic        ov;
        int          n, lat, busy_cnt;
        ref_alu(op, a, b, sh, r, ov, n);
        exp_q.push_back(r);
        @(negedge clk);
        Op = op; A = a; B = b; shamt = sh; start = 1'b1;
        lat = 0; busy_cnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            Op = 4'h6; A = $urandom; B = $urandom; shamt = 5'($urandom);
            if (done) break;
            if (busy) busy_cnt++;
            check("hold_during_shift", result, exp_prev);
            if (busy && $urandom_range(0, 2) == 0) start = 1'b1;
        end
        got_exp = exp_q.pop_front();
        check("latency", 32'(lat), 32'(n + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(n));
        check("result", result, got_exp);
        check("zero", {31'b0, zero}, {31'b0, got_exp == 32'h0});
        check("overflow", {31'b0, overflow}, {31'b0, ov});
        exp_prev = got_exp;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; Op = 0; A = 0; B = 0; shamt = 0;
        exp_prev = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_flags", {30'b0, busy, done}, 32'd0);
        rst_n = 1'b1;

        run_op(4'h6, 32'h7FFFFFFF, 32'h1, 5'd0);
        run_op(4'hC, 32'hFFFFFFFF, 32'h1, 5'd0);
        run_op(4'hD, 32'hFFFFFFFF, 32'h1, 5'd0);
        run_op(4'h2, 32'h0, 32'h80000000, 5'd4);
        run_op(4'h3, 32'd31, 32'h1, 5'd0);
        run_op(4'h7, 32'h80000000, 32'h1, 5'd0);
        run_op(4'h7, 32'd5, 32'd5, 5'd0);
        run_op(4'h1, 32'h0, 32'hDEADBEEF, 5'd0);
        run_op(4'h5, 32'd31, 32'h80000000, 5'd3);

        // Back-to-back with start held high.
        @(negedge clk);
        Op = 4'hE; A = 32'h0; B = 32'h00001234; start = 1'b1;
        @(negedge clk);
        check("b2b_done1", {31'b0, done}, 32'd1);
        check("b2b_lui", result, 32'h12340000);
        Op = 4'hF; A = 32'h12340000; B = 32'h000000FF;
        @(negedge clk);
        check("b2b_done2", {31'b0, done}, 32'd1);
        check("b2b_ori", result, 32'h123400FF);
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle", {31'b0, done}, 32'd0);
        exp_prev = 32'h123400FF;

        // Reset in the middle of a shift.
        Op = 4'h2; B = 32'h80000000; shamt = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_zero", {31'b0, zero}, 32'd1);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("no_done_after_rst", 32'(seen), 32'd0);
        end
        exp_prev = 32'h0;

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h7FFFFFFF;
                1: rb = 32'h80000000;
                2: rb = ra;
                default: ;
            endcase
            if (rop >= 4'd3 && rop <= 4'd5) ra[4:0] = 5'($urandom_range(0, 8));
            run_op(rop, ra, rb, 5'($urandom_range(0, 9)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
